chan_matrix_loader: RTL and testbench

- Upstream stage of QR_decomp4 in the MIMO-OFDM channel-estimation path.
- Accepts a serial stream of IEEE-754 single-precision channel coefficients and assembles them row-major into a DIMxDIM matrix.
- Double-buffered: one bank fills while the other is held stable and presented to the QR decomposition under a valid/ready handshake.
- Checks frame length and counts dropped frames.

---
 rtl/chan_matrix_loader.sv | 145 ++++++++++++++
 tb/tb_chan_matrix_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/chan_matrix_loader.sv
// Double-buffered DIMxDIM matrix loader for QR_decomp4: serial words in, row-major banks out.
// Optional NaN/Inf tagging of output frames is enabled by defining CHAN_NAN_CHECK_EN.
module chan_matrix_loader #(
  parameter int DIM    = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] matrix [0:DIM-1][0:DIM-1],
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_err,
  output logic [7:0]        drop_cnt,
  output logic              nan_flag
);

  localparam int NWORDS = DIM * DIM;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  // Flat row-major storage: index wr_cnt equals row*DIM+col.
  logic [DATA_W-1:0] bank_q [0:1][0:NWORDS-1];

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic accept;
  logic at_last;
  logic frame_done;
  logic frame_bad;
  logic release_bank;

  assign s_ready      = !full_q[wr_bank_q];
  assign m_valid      = full_q[rd_bank_q];
  assign accept       = s_valid && s_ready;
  assign at_last      = (wr_cnt_q == LAST_IDX);
  assign frame_done   = accept && s_last && at_last;
  // A misplaced s_last or a missing one at the final index both abort the frame.
  assign frame_bad    = accept && (s_last != at_last);
  assign release_bank = m_valid && m_ready;

  assign frame_err = frame_err_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    wr_cnt_d    = wr_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    frame_err_d = frame_bad;

    if (frame_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      wr_cnt_d          = '0;
    end else if (frame_bad) begin
      wr_cnt_d = '0;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (accept) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    // Fill and release always target different banks, so both may apply.
    if (release_bank) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      wr_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      drop_cnt_q  <= 8'd0;
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < NWORDS; w++) begin
          bank_q[b][w] <= '0;
        end
      end
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      wr_cnt_q    <= wr_cnt_d;
      frame_err_q <= frame_err_d;
      drop_cnt_q  <= drop_cnt_d;
      if (accept) begin
        bank_q[wr_bank_q][wr_cnt_q] <= s_data;
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_row
      for (gj = 0; gj < DIM; gj++) begin : g_col
        assign matrix[gi][gj] = bank_q[rd_bank_q][gi*DIM+gj];
      end
    end
  endgenerate

`ifdef CHAN_NAN_CHECK_EN
  logic [1:0] nan_q, nan_d;

  always_comb begin
    nan_d = nan_q;
    if (accept && (s_data[30:23] == 8'hFF)) begin
      nan_d[wr_bank_q] = 1'b1;
    end
    if (frame_bad) begin
      nan_d[wr_bank_q] = 1'b0;
    end
    if (release_bank) begin
      nan_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nan_q <= 2'b00;
    end else begin
      nan_q <= nan_d;
    end
  end

  assign nan_flag = nan_q[rd_bank_q] && m_valid;
`else
  assign nan_flag = 1'b0;
`endif

endmodule

// File: tb/tb_chan_matrix_loader.sv
// Directed bench for chan_matrix_loader: delivery, back-pressure, framing errors, reset, NaN tagging.
module tb_chan_matrix_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] matrix [0:3][0:3];
  logic        m_valid;
  logic        m_ready;
  logic        frame_err;
  logic [7:0]  drop_cnt;
  logic        nan_flag;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef CHAN_NAN_CHECK_EN
  localparam logic NAN_EXP = 1'b1;
`else
  localparam logic NAN_EXP = 1'b0;
`endif

  logic [31:0] frame0 [0:15] = '{
    32'h3F4ECCB8, 32'h3E9A1F2C, 32'hBD8C4A11, 32'h3C2B7E90,
    32'h3F01A3C5, 32'h3DCB32B5, 32'hBE3377AA, 32'h3D11C0DE,
    32'hBF22E1B4, 32'h3E5C8A0F, 32'h3F6B2D71, 32'hBC9F3E28,
    32'h3D7A44B1, 32'hBE0F5D62, 32'h3C4E9173, 32'h3E0A8D9F
  };

  chan_matrix_loader #(.DIM(4), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .matrix   (matrix),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .frame_err(frame_err),
    .drop_cnt (drop_cnt),
    .nan_flag (nan_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fword(input int f, input int i);
    if (f == 0) return frame0[i];
    return 32'h4000_0000 | 32'(f << 8) | 32'(i);
  endfunction

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic push(input logic [31:0] d, input logic last);
    int t = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("push_timeout", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int f, input logic last_ok);
    for (int i = 0; i < 16; i++) push(fword(f, i), (i == 15) && last_ok);
  endtask

  task automatic check_frame(input string tag, input int f);
    chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
    chk({tag, "_m00"}, matrix[0][0], fword(f, 0));
    chk({tag, "_m12"}, matrix[1][2], fword(f, 6));
    chk({tag, "_m33"}, matrix[3][3], fword(f, 15));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    reset   = 1'b1;
    s_data  = 32'd0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_nan", 32'(nan_flag), 32'd0);
    chk("rst_m00", matrix[0][0], 32'd0);

    // First frame, consumer always ready
    for (int i = 0; i < 15; i++) push(fword(0, i), 1'b0);
    chk("f0_mv_early", 32'(m_valid), 32'd0);
    push(fword(0, 15), 1'b1);
    chk("f0_mvalid", 32'(m_valid), 32'd1);
    chk("f0_m00", matrix[0][0], 32'h3F4ECCB8);
    chk("f0_m11", matrix[1][1], 32'h3DCB32B5);
    chk("f0_m33", matrix[3][3], 32'h3E0A8D9F);
    @(negedge clk);
    chk("f0_released", 32'(m_valid), 32'd0);

    // Back-pressure: two banks fill, third frame stalls
    m_ready = 1'b0;
    send_frame(1, 1'b1);
    chk("bp_f1_ready", 32'(s_ready), 32'd1);
    send_frame(2, 1'b1);
    chk("bp_full_ready", 32'(s_ready), 32'd0);
    chk("bp_f1_m00", matrix[0][0], fword(1, 0));
    s_data  = fword(3, 0);
    s_valid = 1'b1;
    s_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_hold_m33", matrix[3][3], fword(1, 15));
    chk("bp_hold_ready", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check_frame("bp_f2", 2);
    chk("bp_f2_ready", 32'(s_ready), 32'd1);
    send_frame(3, 1'b1);
    chk("bp_f3_full", 32'(s_ready), 32'd0);
    check_frame("bp_f2_still", 2);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check_frame("bp_f3", 3);
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_drained", 32'(m_valid), 32'd0);

    // Early s_last on word 9
    for (int i = 0; i < 10; i++) push(fword(4, i), i == 9);
    chk("early_ferr", 32'(frame_err), 32'd1);
    chk("early_drop", 32'(drop_cnt), 32'd1);
    chk("early_mvalid", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("early_ferr_pulse", 32'(frame_err), 32'd0);
    send_frame(5, 1'b1);
    check_frame("after_err", 5);
    @(negedge clk);

    // Missing s_last: 300 dropped frames, counter saturates
    for (int k = 0; k < 300; k++) begin
      send_frame(6, 1'b0);
      if (k == 0) chk("miss_ferr", 32'(frame_err), 32'd1);
      if (k == 99) chk("miss_drop101", 32'(drop_cnt), 32'd101);
    end
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    chk("sat_mvalid", 32'(m_valid), 32'd0);

    // Reset mid-frame
    for (int i = 0; i < 8; i++) push(fword(7, i), 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("mrst_drop", 32'(drop_cnt), 32'd0);
    chk("mrst_mvalid", 32'(m_valid), 32'd0);
    chk("mrst_ready", 32'(s_ready), 32'd1);
    chk("mrst_m12", matrix[1][2], 32'd0);
    @(negedge clk);
    send_frame(8, 1'b1);
    check_frame("mrst_f8", 8);
    chk("mrst_drop_after", 32'(drop_cnt), 32'd0);
    @(negedge clk);

    // NaN word at index 5
    for (int i = 0; i < 16; i++) push((i == 5) ? 32'h7FC00000 : fword(9, i), i == 15);
    chk("nan_mvalid", 32'(m_valid), 32'd1);
    chk("nan_m11", matrix[1][1], 32'h7FC00000);
    chk("nan_flag", 32'(nan_flag), 32'(NAN_EXP));
    @(negedge clk);
    chk("nan_after_rel", 32'(nan_flag), 32'd0);
    send_frame(10, 1'b1);
    check_frame("clean_f10", 10);
    chk("clean_nan", 32'(nan_flag), 32'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
